key_schedule: RTL
=================

KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 The block SHALL have parameter word_size, default 8, meaning the byte width in bits.
REQ-002 The block SHALL have parameter array_size, default 16, meaning the number of bytes per key; only 8/16 SHALL be supported (AES-128).
REQ-003 The block SHALL have a single clock, clk, and reset is asynchronous and active-high on rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-007 key_in  input  128  cipher key; FIPS-197 byte i at bits [8i+7:8i].
REQ-008 key_ready  input  1  consumer (AddRoundKey stage) accepts round_key this cycle.
REQ-009 round_key  output  128  current round key, same byte packing as key_in.
REQ-010 round_num  output  4  index 0..10 of round_key.
REQ-011 key_valid  output  1  round_key/round_num valid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after round 10 key is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, SERVE, FINISH.
REQ-015 IDLE: start=1 at an edge SHALL register key_in into round_key, set round_num=0, key_valid=1, busy=1, and go to SERVE.
REQ-016 SERVE: a transfer SHALL occur at any edge where key_valid=1 and key_ready=1.
REQ-017 SERVE with no transfer SHALL hold round_key, round_num, key_valid unchanged (no stalls lost, no skips).
REQ-018 SERVE transfer with round_num<10 SHALL load the next round key and increment round_num, keeping key_valid=1; throughput is one key per cycle while key_ready is held high.
REQ-019 Next key, words w0..w3 of the current key (w_j = bytes 4j..4j+3, byte 4j most significant in AES word order): t = SubWord(RotWord(w3)) xor Rcon[r+1]; n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
REQ-020 RotWord SHALL move byte 4j+1..4j+3 to positions 0..2 and byte 0 to position 3; SubWord SHALL apply the AES forward S-box per byte; Rcon[r+1] SHALL xor only the first byte of t.
REQ-021 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-022 SERVE transfer with round_num=10 SHALL clear key_valid and go to FINISH.
REQ-023 FINISH SHALL assert done for exactly that one cycle, then go to IDLE with busy=0.
REQ-024 start SHALL be ignored in SERVE and FINISH; start in FINISH SHALL not be queued.
REQ-025 In IDLE, round_key and round_num SHALL retain their last values; key_valid SHALL be 0.
REQ-026 key_in SHALL be sampled only on the accepting start edge; later changes SHALL not affect the sequence.
REQ-027 key_ready while key_valid=0 SHALL have no effect.
REQ-028 All outputs SHALL be registered; no combinational path from key_ready or start to any output.

Reset
REQ-029 rst=1 SHALL immediately, without clk, force state IDLE, round_key=0, round_num=0, key_valid=0, busy=0, done=0.
REQ-030 rst asserted mid-sequence SHALL abandon the sequence; after release, the next start SHALL begin from round 0.
REQ-031 The first edge with rst=0 and start=1 SHALL be accepted normally.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, key_ready=1 -> round 0 equals key, round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 (FIPS byte order), keys on 11 consecutive cycles, done 1 cycle after round 10.
REQ-033 Same key, key_ready toggled pseudo-randomly -> identical 11-key sequence, outputs stable on every stalled cycle, exactly 11 transfers.
REQ-034 All-zero key -> round 1 62636363626363636263636362636363, round 10 b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-035 start pulsed during SERVE with a different key_in -> ignored, original sequence completes unchanged.
REQ-036 rst asserted between clock edges at round_num=5 -> outputs zero immediately; new start after release yields round_num=0 with the new key.
REQ-037 key_ready held low 20 cycles after start -> round_num stays 0, key_valid stays 1, done never asserted.

Source files
------------

// File: rtl/key_schedule.sv
// AES-128 key schedule: expands key_in into round keys 0..10, one per
// accepted handshake. Bytes packed LSB-first (byte i at bits [8i+7:8i]).
//
// Ports:
//   clk, rst     rising-edge clock, async active-high reset
//   start        begin expansion of key_in (sampled in IDLE only)
//   key_in       cipher key
//   key_ready    consumer accepts round_key this cycle
//   round_key    current round key (registered)
//   round_num    index 0..10 of round_key
//   key_valid    round_key/round_num valid
//   busy         high outside IDLE
//   done         one-cycle pulse after round 10 is accepted
module key_schedule #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [word_size*array_size-1:0] key_in,
    input  logic                            key_ready,
    output logic [word_size*array_size-1:0] round_key,
    output logic [3:0]                      round_num,
    output logic                            key_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int         WW   = 4 * word_size;
    localparam logic [3:0] LAST = 4'd10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        FINISH
    } state_t;

    state_t state;

    logic [7:0]    rcon;
    logic [WW-1:0] t;
    logic [WW-1:0] n0;
    logic [WW-1:0] n1;
    logic [WW-1:0] n2;
    logic [WW-1:0] n3;

    function automatic logic [7:0] sub(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Rcon for the round being produced (round_num + 1).
    always_comb begin
        rcon = 8'h00;
        case (round_num)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // t = SubWord(RotWord(w3)) ^ Rcon; w3 is bytes 12..15, so the
    // rotated word starts with byte 13 and ends with byte 12.
    always_comb begin
        t = {sub(round_key[12*8 +: 8]),
             sub(round_key[15*8 +: 8]),
             sub(round_key[14*8 +: 8]),
             sub(round_key[13*8 +: 8]) ^ rcon};
        n0 = round_key[0*WW +: WW] ^ t;
        n1 = round_key[1*WW +: WW] ^ n0;
        n2 = round_key[2*WW +: WW] ^ n1;
        n3 = round_key[3*WW +: WW] ^ n2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_num <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        round_key <= key_in;
                        round_num <= '0;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (key_valid && key_ready) begin
                        if (round_num == LAST) begin
                            key_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            round_key <= {n3, n2, n1, n0};
                            round_num <= round_num + 4'd1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
